// File: rtl/trig_share_arbiter.sv
// Two-requester arbiter sharing a single trig unit between an argument path (A)
// and a theta path (B), with round-robin tie-break and a WAIT-state timeout.
module trig_share_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_a,
    input  logic [15:0] op_a,
    input  logic        req_b,
    input  logic [15:0] op_b,
    output logic        unit_start,
    output logic [15:0] unit_op,
    input  logic        unit_done,
    input  logic [31:0] unit_result,
    output logic        done_a,
    output logic        done_b,
    output logic [31:0] result,
    output logic        busy,
    output logic        timeout,
    output logic [2:0]  db_estado
);

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StStart   = 3'd1,
        StWait    = 3'd2,
        StDeliver = 3'd3,
        StAbort   = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic        r_owner;        // 0 = A, 1 = B
    logic        r_last_served;  // 0 = A, 1 = B
    logic [15:0] r_count;
    logic [15:0] r_unit_op;
    logic [31:0] r_result;

    logic        w_grant_valid;
    logic        w_grant_b;
    logic        w_wait_limit;

    // On a tie, B wins only if A was served last.
    assign w_grant_valid = req_a | req_b;
    assign w_grant_b     = req_b & (~req_a | ~r_last_served);
    assign w_wait_limit  = (r_count == 16'(TIMEOUT_CYCLES - 1));

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle: begin
                if (w_grant_valid) begin
                    w_state_next = StStart;
                end
            end
            StStart: w_state_next = StWait;
            StWait: begin
                if (unit_done) begin
                    w_state_next = StDeliver;
                end else if (w_wait_limit) begin
                    w_state_next = StAbort;
                end
            end
            StDeliver: w_state_next = StIdle;
            StAbort:   w_state_next = StIdle;
            default:   w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= StIdle;
            r_owner       <= 1'b0;
            r_last_served <= 1'b1;
            r_count       <= 16'd0;
            r_unit_op     <= 16'd0;
            r_result      <= 32'd0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                StIdle: begin
                    if (w_grant_valid) begin
                        r_owner   <= w_grant_b;
                        r_unit_op <= w_grant_b ? op_b : op_a;
                    end
                end
                StStart: r_count <= 16'd0;
                StWait: begin
                    if (unit_done) begin
                        r_result <= unit_result;
                    end else if (w_wait_limit) begin
                        r_result <= 32'd0;
                    end else begin
                        r_count <= r_count + 16'd1;
                    end
                end
                StDeliver: r_last_served <= r_owner;
                StAbort:   r_last_served <= r_owner;
                default: ;
            endcase
        end
    end

    logic w_finish;
    assign w_finish   = (r_state == StDeliver) || (r_state == StAbort);

    assign unit_start = (r_state == StStart);
    assign unit_op    = r_unit_op;
    assign done_a     = w_finish & ~r_owner;
    assign done_b     = w_finish & r_owner;
    assign result     = r_result;
    assign busy       = (r_state != StIdle);
    assign timeout    = (r_state == StAbort);
    assign db_estado  = r_state;

endmodule

// File: tb/tb_trig_share_arbiter.sv
// Directed self-checking bench for trig_share_arbiter, built with an 8-cycle timeout.
module tb_trig_share_arbiter;

    localparam int unsigned TimeoutCycles = 8;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_a = 1'b0;
    logic [15:0] op_a = 16'd0;
    logic        req_b = 1'b0;
    logic [15:0] op_b = 16'd0;
    logic        unit_start;
    logic [15:0] unit_op;
    logic        unit_done = 1'b0;
    logic [31:0] unit_result = 32'd0;
    logic        done_a;
    logic        done_b;
    logic [31:0] result;
    logic        busy;
    logic        timeout;
    logic [2:0]  db_estado;

    int n_checks = 0;
    int n_fail = 0;
    int n_start = 0;
    int start_snap;

    trig_share_arbiter #(
        .TIMEOUT_CYCLES(TimeoutCycles)
    ) u_dut (
        .clock      (clock),
        .reset      (reset),
        .req_a      (req_a),
        .op_a       (op_a),
        .req_b      (req_b),
        .op_b       (op_b),
        .unit_start (unit_start),
        .unit_op    (unit_op),
        .unit_done  (unit_done),
        .unit_result(unit_result),
        .done_a     (done_a),
        .done_b     (done_b),
        .result     (result),
        .busy       (busy),
        .timeout    (timeout),
        .db_estado  (db_estado)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (unit_start) n_start <= n_start + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    // Both requests held high; serves one transaction and checks the owner.
    task automatic serve(input logic own_b, input logic [31:0] res, input string tag);
        step();
        check_eq({tag, "_start"}, {31'd0, unit_start}, 32'd1);
        check_eq({tag, "_op"}, {16'd0, unit_op}, own_b ? 32'h2222 : 32'h1111);
        step();
        check_eq({tag, "_wait"}, {29'd0, db_estado}, 32'd2);
        check_eq({tag, "_start_off"}, {31'd0, unit_start}, 32'd0);
        unit_done = 1'b1;
        unit_result = res;
        step();
        unit_done = 1'b0;
        check_eq({tag, "_deliver"}, {29'd0, db_estado}, 32'd3);
        check_eq({tag, "_done_a"}, {31'd0, done_a}, {31'd0, ~own_b});
        check_eq({tag, "_done_b"}, {31'd0, done_b}, {31'd0, own_b});
        check_eq({tag, "_result"}, result, res);
        step();
        check_eq({tag, "_idle"}, {29'd0, db_estado}, 32'd0);
    endtask

    initial begin
        // Reset with noise on the inputs: nothing may escape IDLE.
        req_a = 1'b1;
        unit_done = 1'b1;
        unit_result = 32'h1357_9BDF;
        step();
        step();
        check_eq("rst_state", {29'd0, db_estado}, 32'd0);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_start", {31'd0, unit_start}, 32'd0);
        check_eq("rst_done", {30'd0, done_a, done_b}, 32'd0);
        check_eq("rst_timeout", {31'd0, timeout}, 32'd0);
        check_eq("rst_result", result, 32'd0);
        check_eq("rst_unit_op", {16'd0, unit_op}, 32'd0);
        req_a = 1'b0;
        unit_done = 1'b0;
        reset = 1'b0;

        // Alternating service on permanent tie, A first after reset.
        op_a = 16'h1111;
        op_b = 16'h2222;
        req_a = 1'b1;
        req_b = 1'b1;
        serve(1'b0, 32'hA000_0001, "tie1");
        serve(1'b1, 32'hB000_0002, "tie2");
        serve(1'b0, 32'hA000_0003, "tie3");
        req_a = 1'b1;
        serve(1'b1, 32'hB000_0004, "tie4");
        req_a = 1'b0;
        req_b = 1'b0;
        step();

        // Single request from A, done after 5 cycles.
        start_snap = n_start;
        op_a = 16'h1234;
        req_a = 1'b1;
        step();
        check_eq("a_start", {31'd0, unit_start}, 32'd1);
        check_eq("a_op", {16'd0, unit_op}, 32'h1234);
        step();
        for (int i = 0; i < 4; i++) begin
            step();
            check_eq("a_no_early_done", {31'd0, done_a}, 32'd0);
        end
        unit_done = 1'b1;
        unit_result = 32'hCAFE_0001;
        step();
        unit_done = 1'b0;
        check_eq("a_done_a", {31'd0, done_a}, 32'd1);
        check_eq("a_done_b", {31'd0, done_b}, 32'd0);
        check_eq("a_result", result, 32'hCAFE_0001);
        check_eq("a_op_hold", {16'd0, unit_op}, 32'h1234);
        check_eq("a_start_count", n_start - start_snap, 32'd1);
        req_a = 1'b0;
        step();
        check_eq("a_idle", {29'd0, db_estado}, 32'd0);
        check_eq("a_idle_done", {31'd0, done_a}, 32'd0);

        // Timeout on B: 8 WAIT cycles, then ABORT.
        op_b = 16'hBEEF;
        req_b = 1'b1;
        step();
        step();
        for (int i = 0; i < 7; i++) begin
            step();
            check_eq("to_still_wait", {29'd0, db_estado}, 32'd2);
            check_eq("to_no_timeout", {31'd0, timeout}, 32'd0);
        end
        step();
        check_eq("to_abort", {29'd0, db_estado}, 32'd4);
        check_eq("to_timeout", {31'd0, timeout}, 32'd1);
        check_eq("to_done_b", {31'd0, done_b}, 32'd1);
        check_eq("to_done_a", {31'd0, done_a}, 32'd0);
        check_eq("to_result", result, 32'd0);
        req_b = 1'b0;
        step();
        check_eq("to_idle", {29'd0, db_estado}, 32'd0);
        check_eq("to_pulse_end", {31'd0, timeout}, 32'd0);

        // unit_done on the very limit cycle wins over timeout.
        op_a = 16'h0036;
        req_a = 1'b1;
        step();
        step();
        for (int i = 0; i < 7; i++) step();
        unit_done = 1'b1;
        unit_result = 32'h5A5A_5A5A;
        step();
        unit_done = 1'b0;
        req_a = 1'b0;
        check_eq("lim_deliver", {29'd0, db_estado}, 32'd3);
        check_eq("lim_no_timeout", {31'd0, timeout}, 32'd0);
        check_eq("lim_done_a", {31'd0, done_a}, 32'd1);
        check_eq("lim_result", result, 32'h5A5A_5A5A);
        step();

        // Reset mid-WAIT, then a late unit_done.
        op_b = 16'h0037;
        req_b = 1'b1;
        step();
        step();
        step();
        check_eq("mr_in_wait", {29'd0, db_estado}, 32'd2);
        reset = 1'b1;
        req_b = 1'b0;
        step();
        reset = 1'b0;
        check_eq("mr_state", {29'd0, db_estado}, 32'd0);
        check_eq("mr_busy", {31'd0, busy}, 32'd0);
        check_eq("mr_result", result, 32'd0);
        check_eq("mr_done", {30'd0, done_a, done_b}, 32'd0);
        unit_done = 1'b1;
        unit_result = 32'hFFFF_FFFF;
        step();
        check_eq("late_state", {29'd0, db_estado}, 32'd0);
        check_eq("late_done", {30'd0, done_a, done_b}, 32'd0);
        check_eq("late_result", result, 32'd0);
        check_eq("late_timeout", {31'd0, timeout}, 32'd0);

        // Spurious unit_done held through IDLE and START.
        unit_result = 32'hDEAD_BEEF;
        op_a = 16'h0F0F;
        req_a = 1'b1;
        step();
        check_eq("sp_start", {29'd0, db_estado}, 32'd1);
        step();
        unit_done = 1'b0;
        check_eq("sp_wait", {29'd0, db_estado}, 32'd2);
        check_eq("sp_result", result, 32'd0);
        check_eq("sp_done_a", {31'd0, done_a}, 32'd0);
        step();
        step();
        unit_done = 1'b1;
        unit_result = 32'h0000_0077;
        step();
        unit_done = 1'b0;
        req_a = 1'b0;
        check_eq("sp_deliver_a", {31'd0, done_a}, 32'd1);
        check_eq("sp_deliver_res", result, 32'h0000_0077);
        step();
        check_eq("sp_idle", {29'd0, db_estado}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/trig_share_arbiter.md
TRIG_SHARE_ARBITER -- requirements
Module: trig_share_arbiter

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 255: maximum WAIT-state cycles allowed before the block aborts a transaction.
REQ-002 The block SHALL have port clock, input, 1: the single system clock; all logic SHALL be clocked on its rising edge.
REQ-003 The block SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-004 The block SHALL have port req_a, input, 1: level request from requester A (argument path).
REQ-005 The block SHALL have port op_a, input, 16: operand from requester A.
REQ-006 The block SHALL have port req_b, input, 1: level request from requester B (theta path).
REQ-007 The block SHALL have port op_b, input, 16: operand from requester B.
REQ-008 The block SHALL have port unit_start, output, 1: one-cycle start pulse to the shared trig unit.
REQ-009 The block SHALL have port unit_op, output, 16: latched operand driven to the shared trig unit.
REQ-010 The block SHALL have port unit_done, input, 1: completion pulse from the shared trig unit.
REQ-011 The block SHALL have port unit_result, input, 32: result from the shared trig unit, valid while unit_done is high.
REQ-012 The block SHALL have port done_a, output, 1: one-cycle completion pulse to requester A.
REQ-013 The block SHALL have port done_b, output, 1: one-cycle completion pulse to requester B.
REQ-014 The block SHALL have port result, output, 32: registered result of the last transaction.
REQ-015 The block SHALL have port busy, output, 1: high whenever the state is not IDLE.
REQ-016 The block SHALL have port timeout, output, 1: one-cycle pulse when a transaction is aborted.
REQ-017 The block SHALL have port db_estado, output, 3: state code, IDLE=0, START=1, WAIT=2, DELIVER=3, ABORT=4.

Function
REQ-018 The block SHALL implement the FSM IDLE->START->WAIT->(DELIVER|ABORT)->IDLE; any unused state code SHALL go to IDLE.
REQ-019 In IDLE with only one request high, the block SHALL grant that requester; with both high, it SHALL grant the requester not recorded in last_served.
REQ-020 On leaving IDLE, the block SHALL latch the grant owner and the owner's operand into unit_op; unit_op SHALL hold that value until the next grant.
REQ-021 The block SHALL assert unit_start only in START, for exactly one cycle: the cycle after the request was sampled in IDLE.
REQ-022 The block SHALL sample unit_done only in WAIT; unit_done in any other state SHALL be ignored.
REQ-023 In WAIT, a 16-bit wait counter SHALL start at 0 on entry and increment each cycle.
REQ-024 In WAIT, if unit_done=1, the block SHALL capture unit_result into result and go to DELIVER; unit_done has priority over timeout in the same cycle.
REQ-025 In WAIT, if the counter equals TIMEOUT_CYCLES-1 and unit_done=0, the block SHALL go to ABORT.
REQ-026 In DELIVER, the block SHALL pulse done of the owner only, set last_served to the owner, and go to IDLE.
REQ-027 In ABORT, the block SHALL set result to 0, pulse timeout and done of the owner, set last_served to the owner, and go to IDLE.
REQ-028 Owner done therefore SHALL assert exactly one cycle after unit_done.
REQ-029 A request still high in IDLE after delivery SHALL be treated as a new request; requesters deassert req after seeing done.
REQ-030 Requests arriving while busy SHALL be held off (not queued) and evaluated when the block next enters IDLE.

Reset
REQ-031 While reset=1 at a clock edge, the block SHALL set state to IDLE, last_served to B (so A wins the first tie), counter to 0, unit_op=0, result=0, and unit_start, done_a, done_b, timeout, busy, db_estado to 0.
REQ-032 A reset asserted mid-transaction SHALL abort it silently with no done or timeout pulse; a late unit_done SHALL then be ignored.

Verification
REQ-033 req_a=1, op_a=0x1234, unit_done after 5 cycles with unit_result=0xCAFE0001 -> unit_op=0x1234, single unit_start, result=0xCAFE0001, done_a pulse one cycle after unit_done, done_b=0.
REQ-034 req_a and req_b both high from reset, each served -> A granted first, then B; repeat with both high -> A, then B again (alternating).
REQ-035 TIMEOUT_CYCLES=8, req_b=1, no unit_done -> ABORT entered after 8 WAIT cycles, timeout and done_b pulse together, result=0.
REQ-036 unit_done in the same cycle the counter hits the limit -> DELIVER, no timeout pulse.
REQ-037 reset during WAIT, then unit_done -> state IDLE, no done pulse, result=0.
REQ-038 Spurious unit_done in IDLE and in START -> ignored, no state change beyond the normal flow.
